// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op encodings, instruction
// field positions, FSM states and the decoded-instruction record.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_PASSA = 3'b010,
    ALU_PASSB = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_NOT   = 3'b110,
    ALU_XOR   = 3'b111
  } alu_op_e;

  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned CF_BIT   = 3;
  localparam int unsigned RD_LSB   = 4;
  localparam int unsigned RA_LSB   = 7;
  localparam int unsigned RB_LSB   = 10;
  localparam int unsigned IMM_BIT  = 13;
  localparam int unsigned IMMV_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OPER = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  // Instruction word minus the ignored bits [15:14]
  typedef struct packed {
    logic [15:0] immv;
    logic        imm;
    logic [2:0]  rb;
    logic [2:0]  ra;
    logic [2:0]  rd;
    logic        cf;
    logic [2:0]  op;
  } instr_dec_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero, asynchronous active-low clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ALU: accepts one instruction per handshake,
// registers ALU operands, captures the result, writes it back and updates Z/C.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_s,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_f,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          flag_z,
  output logic          flag_c
);

  state_e        state_q, state_d;
  instr_dec_t    dec_q;
  logic [DW-1:0] alu_a_q, alu_b_q, result_q;
  logic [2:0]    alu_s_q;
  logic          alu_cin_q, flag_z_q, flag_c_q;

  logic [DW-1:0] rdata_a, rdata_b, imm_ext, opnd_b, carry_b;
  logic [DW:0]   carry_sum;
  logic          unused_rsvd;

  assign unused_rsvd = ^instr[15:14];

  alu_regfile #(
    .NREG (NREG),
    .AW   (AW),
    .DW   (DW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (wb_en),
    .waddr_i   (dec_q.rd),
    .wdata_i   (result_q),
    .raddr_a_i (dec_q.ra),
    .rdata_a_o (rdata_a),
    .raddr_b_i (dec_q.rb),
    .rdata_b_o (rdata_b)
  );

  assign imm_ext = {{(DW-16){dec_q.immv[15]}}, dec_q.immv};
  assign opnd_b  = dec_q.imm ? imm_ext : rdata_b;

  // Carry is recomputed at WB from the still-held operand registers
  assign carry_b   = (alu_s_q == ALU_SUB) ? ~alu_b_q : alu_b_q;
  assign carry_sum = {1'b0, alu_a_q} + {1'b0, carry_b} + {{DW{1'b0}}, alu_cin_q};

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wb_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_OPER;
      end
      ST_OPER: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dec_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_s_q   <= '0;
      alu_cin_q <= 1'b0;
      result_q  <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && instr_valid) begin
        dec_q <= '{immv: instr[IMMV_LSB +: 16], imm: instr[IMM_BIT],
                   rb: instr[RB_LSB +: 3], ra: instr[RA_LSB +: 3],
                   rd: instr[RD_LSB +: 3], cf: instr[CF_BIT], op: instr[OP_LSB +: 3]};
      end
      if (state_q == ST_OPER) begin
        alu_a_q   <= rdata_a;
        alu_b_q   <= opnd_b;
        alu_s_q   <= dec_q.op;
        alu_cin_q <= dec_q.cf ? flag_c_q : (dec_q.op == ALU_SUB);
      end
      if (state_q == ST_EXEC) result_q <= alu_f;
      if (state_q == ST_WB) begin
        flag_z_q <= (result_q == '0);
        if ((alu_s_q == ALU_ADD) || (alu_s_q == ALU_SUB)) flag_c_q <= carry_sum[DW];
      end
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_s   = alu_s_q;
  assign alu_cin = alu_cin_q;
  assign wb_addr = dec_q.rd;
  assign wb_data = result_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_a, alu_b, alu_f, wb_data;
  logic [2:0]  alu_s, wb_addr;
  logic        alu_cin, wb_en, flag_z, flag_c;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .NREG (8),
    .AW   (3),
    .DW   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_cin     (alu_cin),
    .alu_f       (alu_f),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    case (s)
      3'd0:    return a + b + {31'b0, cin};
      3'd1:    return a + ~b + {31'b0, cin};
      3'd2:    return a;
      3'd3:    return b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return ~a;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_f = alu_fn(alu_s, alu_a, alu_b, alu_cin);

  function automatic logic [31:0] mk(input logic [2:0] op, input logic cf, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic imm, input logic [15:0] iv);
    return {iv, 2'b00, imm, rb, ra, rd, cf, op};
  endfunction

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
    logic        z;
    logic        c;
    int unsigned acc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        fx;
  logic        flag_pend = 1'b0;
  logic [31:0] mr[8];
  logic        mz, mc;
  int unsigned cyc = 0;
  int unsigned last_acc;
  int unsigned nchk = 0;
  int unsigned nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = '0;
    mz = 1'b0;
    mc = 1'b0;
  endtask

  // Drives one instruction, computes its expected outcome and queues it
  task automatic issue(input logic [31:0] w, input bit hold);
    logic [31:0] ins, a, b, r;
    logic [32:0] sum;
    logic        cin;
    int unsigned n;
    ins = w;
    ins[15:14] = 2'($urandom_range(0, 3));
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", {31'b0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    a   = (w[9:7] == 3'd0) ? 32'd0 : mr[w[9:7]];
    b   = w[13] ? {{16{w[31]}}, w[31:16]} : ((w[12:10] == 3'd0) ? 32'd0 : mr[w[12:10]]);
    cin = w[3] ? mc : (w[2:0] == 3'd1);
    r   = alu_fn(w[2:0], a, b, cin);
    if (w[2:1] == 2'b00) begin
      sum = {1'b0, a} + {1'b0, (w[0] ? ~b : b)} + {32'b0, cin};
      mc  = sum[32];
    end
    mz = (r == 32'd0);
    if (w[6:4] != 3'd0) mr[w[6:4]] = r;
    sb_q.push_back('{rd: w[6:4], data: r, z: mz, c: mc, acc: cyc});
    last_acc = cyc;
    @(posedge clk);
    if (!hold) begin
      #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sb_q.size() != 0 || flag_pend) && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", sb_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (flag_pend) begin
        chk("flag_z", {31'b0, flag_z}, {31'b0, fx.z});
        chk("flag_c", {31'b0, flag_c}, {31'b0, fx.c});
        flag_pend = 1'b0;
      end
      if (wb_en) begin
        if (sb_q.size() == 0) begin
          chk("wb_unexpected", {31'b0, wb_en}, 32'd0);
        end else begin
          fx = sb_q.pop_front();
          chk("wb_addr", {29'b0, wb_addr}, {29'b0, fx.rd});
          chk("wb_data", wb_data, fx.data);
          chk("latency", cyc - fx.acc, 32'd3);
          flag_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    int unsigned a1, seen;
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst_flag_z", {31'b0, flag_z}, 32'd0);
    chk("rst_flag_c", {31'b0, flag_c}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    for (int k = 1; k < 8; k++) issue(mk(ALU_ADD, 1'b0, 3'd0, 3'(k), 3'(k), 1'b0, 16'd0), 1'b0);

    issue(mk(ALU_ADD, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5), 1'b0);
    issue(mk(ALU_ADD, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7), 1'b0);
    issue(mk(ALU_ADD, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_SUB, 1'b0, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_SUB, 1'b0, 3'd5, 3'd0, 3'd1, 1'b0, 16'd0), 1'b0);

    issue(mk(ALU_ADD, 1'b0, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF), 1'b0);
    issue(mk(ALU_ADD, 1'b0, 3'd7, 3'd6, 3'd6, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_ADD, 1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 16'd0), 1'b0);

    // rd==0 still pulses wb_en; r0 must stay zero afterwards
    issue(mk(ALU_ADD, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9), 1'b0);
    issue(mk(ALU_ADD, 1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 16'd0), 1'b0);

    // Build 0xF0F01234 in r1 and 0x0FF000FF in r2 by doubling
    issue(mk(ALU_ADD, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hF0F0), 1'b0);
    issue(mk(ALU_ADD, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0FF0), 1'b0);
    for (int k = 0; k < 16; k++) begin
      issue(mk(ALU_ADD, 1'b0, 3'd1, 3'd1, 3'd1, 1'b0, 16'd0), 1'b0);
      issue(mk(ALU_ADD, 1'b0, 3'd2, 3'd2, 3'd2, 1'b0, 16'd0), 1'b0);
    end
    issue(mk(ALU_ADD, 1'b0, 3'd1, 3'd1, 3'd0, 1'b1, 16'h1234), 1'b0);
    issue(mk(ALU_ADD, 1'b0, 3'd2, 3'd2, 3'd0, 1'b1, 16'h00FF), 1'b0);
    drain();
    chk("build_r1", mr[1], 32'hF0F0_1234);
    chk("build_r2", mr[2], 32'h0FF0_00FF);

    issue(mk(ALU_ADD, 1'b0, 3'd0, 3'd6, 3'd6, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_PASSA, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_PASSB, 1'b0, 3'd4, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_AND, 1'b0, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_OR, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_NOT, 1'b0, 3'd4, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    issue(mk(ALU_XOR, 1'b0, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
    drain();

    // Valid held through the busy period: next accept only once IDLE
    issue(mk(ALU_ADD, 1'b0, 3'd3, 3'd1, 3'd0, 1'b1, 16'd1), 1'b1);
    a1 = last_acc;
    issue(mk(ALU_SUB, 1'b0, 3'd4, 3'd3, 3'd1, 1'b0, 16'd0), 1'b0);
    chk("accept_gap", last_acc - a1, 32'd4);
    drain();

    // Reset asserted while the instruction sits in EXEC
    @(negedge clk);
    instr = mk(ALU_ADD, 1'b0, 3'd5, 3'd6, 3'd6, 1'b0, 16'd0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("exec_rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("exec_rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("exec_rst_flag_c", {31'b0, flag_c}, 32'd0);
    chk("exec_rst_alu_a", alu_a, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_en) seen++;
    end
    chk("exec_rst_no_wb", seen, 32'd0);
    chk("exec_rst_ready2", {31'b0, instr_ready}, 32'd1);
    for (int k = 1; k < 8; k++) issue(mk(ALU_ADD, 1'b0, 3'd0, 3'(k), 3'(k), 1'b0, 16'd0), 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
